axis_watermark_fifo: RTL and testbench

AXIS_WATERMARK_FIFO -- requirements
Module: axis_watermark_fifo

---
 rtl/axis_watermark_fifo.sv | 122 ++++++++++++
 tb/tb_axis_watermark_fifo.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_watermark_fifo.sv
// AXI-Stream FIFO with registered output stage, watermark flags
// and optional drop-on-full mode with a saturating drop counter.
module axis_watermark_fifo #(
  parameter int DATA_WIDTH       = 256,
  parameter int ADDR_WIDTH       = 10,
  parameter int ALMOST_FULL_LVL  = (1 << ADDR_WIDTH) - 4,
  parameter int ALMOST_EMPTY_LVL = 4,
  parameter bit DROP_WHEN_FULL   = 1'b0
) (
  input  logic                  axis_clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_WIDTH:0] AE_LVL =
    (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic [ADDR_WIDTH:0]   level_post;
  logic                  clr;
  logic                  full;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  drop;
  logic                  load;

  assign clr     = rst | flush;
  assign full    = (level == FULL_LVL);
  // level counts the output register, the RAM holds the remainder
  assign ram_cnt = level - {{ADDR_WIDTH{1'b0}}, m_axis_tvalid};
  assign rd_fire = m_axis_tvalid & m_axis_tready & ~clr;
  assign load    = (ram_cnt != '0) &
                   (~m_axis_tvalid | m_axis_tready);

  generate
    if (DROP_WHEN_FULL) begin : g_drop
      assign s_axis_tready = ~clr;
      assign wr_fire = s_axis_tvalid & ~clr &
                       (~full | rd_fire);
      assign drop    = s_axis_tvalid & ~clr &
                       full & ~rd_fire;
    end else begin : g_hold
      assign s_axis_tready = ~full & ~clr;
      assign wr_fire = s_axis_tvalid & s_axis_tready;
      assign drop    = 1'b0;
    end
  endgenerate

  always_comb begin
    level_nxt = level;
    if (wr_fire && !rd_fire) begin
      level_nxt = level + ONE;
    end else if (!wr_fire && rd_fire) begin
      level_nxt = level - ONE;
    end
    level_post = clr ? '0 : level_nxt;
  end

  always_ff @(posedge axis_clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      drop_count    <= '0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tvalid <= 1'b0;
      almost_full   <= (level_post >= AF_LVL);
      almost_empty  <= (level_post <= AE_LVL);
    end else begin
      level        <= level_nxt;
      almost_full  <= (level_post >= AF_LVL);
      almost_empty <= (level_post <= AE_LVL);
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        rd_ptr        <= rd_ptr + PTR_ONE;
        m_axis_tdata  <= mem[rd_ptr];
        m_axis_tvalid <= 1'b1;
      end else if (rd_fire) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_watermark_fifo.sv
// Self-checking bench for axis_watermark_fifo: scoreboard monitor
// on the hold-mode instance plus scenario tasks for both modes.
module tb_axis_watermark_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [AW:0]   level;
  logic          af;
  logic          ae;
  logic [15:0]   dcnt;

  logic [DW-1:0] d_s_tdata;
  logic          d_s_tvalid;
  logic          d_s_tready;
  logic [DW-1:0] d_m_tdata;
  logic          d_m_tvalid;
  logic          d_m_tready;
  logic [AW:0]   d_level;
  logic          d_af;
  logic          d_ae;
  logic [15:0]   d_dcnt;

  int checks   = 0;
  int failures = 0;

  axis_watermark_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DROP_WHEN_FULL(1'b0)
  ) dut (
    .axis_clk(clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .level(level), .almost_full(af), .almost_empty(ae),
    .drop_count(dcnt)
  );

  axis_watermark_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DROP_WHEN_FULL(1'b1)
  ) dut_d (
    .axis_clk(clk), .rst(rst), .flush(flush),
    .s_axis_tdata(d_s_tdata), .s_axis_tvalid(d_s_tvalid),
    .s_axis_tready(d_s_tready),
    .m_axis_tdata(d_m_tdata), .m_axis_tvalid(d_m_tvalid),
    .m_axis_tready(d_m_tready),
    .level(d_level), .almost_full(d_af), .almost_empty(d_ae),
    .drop_count(d_dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard for the hold-mode instance, sampled mid-cycle
  logic [DW-1:0] sb [$];
  int            m_lvl = 0;
  bit            started = 0;
  bit            hold = 0;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] exp_d;
  logic [AW:0]   exp_lvl;
  logic          exp_rdy;

  always @(negedge clk) begin
    if (started) begin
      exp_lvl = m_lvl[AW:0];
      exp_rdy = (m_lvl < DEPTH) && !flush && !rst;
      checks++;
      if (level !== exp_lvl) begin
        failures++;
        $display("FAIL mon_level got=%0d exp=%0d", level, exp_lvl);
      end
      checks++;
      if (af !== (m_lvl >= AF) || ae !== (m_lvl <= AE)) begin
        failures++;
        $display("FAIL mon_flags got af=%b ae=%b lvl=%0d",
                 af, ae, m_lvl);
      end
      checks++;
      if (s_tready !== exp_rdy) begin
        failures++;
        $display("FAIL mon_tready got=%b exp=%b", s_tready, exp_rdy);
      end
      if (hold) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== hold_data) begin
          failures++;
          $display("FAIL mon_stall got v=%b d=%h exp v=1 d=%h",
                   m_tvalid, m_tdata, hold_data);
        end
      end
      if (m_tvalid && m_tready && !rst && !flush) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL mon_data got=%h exp=<empty>", m_tdata);
        end else begin
          exp_d = sb.pop_front();
          if (m_tdata !== exp_d) begin
            failures++;
            $display("FAIL mon_data got=%h exp=%h", m_tdata, exp_d);
          end
        end
      end
    end
    hold = started && m_tvalid && !m_tready && !rst && !flush;
    hold_data = m_tdata;
    if (rst || flush) begin
      sb.delete();
      m_lvl = 0;
      started = 1;
    end else if (started) begin
      if (s_tvalid && s_tready) begin
        sb.push_back(s_tdata);
        m_lvl++;
      end
      if (m_tvalid && m_tready) m_lvl--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 200 && level != 0; i++) step();
    step();
    checks++;
    if (level !== '0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL drain got lvl=%0d v=%b exp lvl=0 v=0",
               level, m_tvalid);
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || level !== '0) begin
      failures++;
      $display("FAIL reset_out got v=%b d=%h l=%0d exp 0/0/0",
               m_tvalid, m_tdata, level);
    end
    checks++;
    if (af !== 1'b0 || ae !== 1'b1 || dcnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_flags got af=%b ae=%b dc=%0d exp 0/1/0",
               af, ae, dcnt);
    end
    checks++;
    if (d_level !== '0 || d_dcnt !== 16'd0 || d_ae !== 1'b1) begin
      failures++;
      $display("FAIL reset_drop got l=%0d dc=%0d ae=%b exp 0/0/1",
               d_level, d_dcnt, d_ae);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h1;
    step();
    checks++;
    if (m_tvalid !== 1'b0 || level !== 5'd1) begin
      failures++;
      $display("FAIL lat_edge1 got v=%b l=%0d exp v=0 l=1",
               m_tvalid, level);
    end
    s_tdata = 32'h2;
    step();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h1) begin
      failures++;
      $display("FAIL lat_edge2 got v=%b d=%h exp v=1 d=1",
               m_tvalid, m_tdata);
    end
    for (int i = 3; i <= 5; i++) begin
      s_tdata = DW'(i);
      step();
    end
    s_tvalid = 1'b0;
    checks++;
    if (level !== 5'd5 || ae !== 1'b0 || af !== 1'b0) begin
      failures++;
      $display("FAIL lat_level got l=%0d ae=%b af=%b exp 5/0/0",
               level, ae, af);
    end
    drain();
  endtask

  task automatic test_fill();
    int  n = 0;
    bit  acc;
    m_tready = 1'b0;
    for (int i = 0; i < 40 && n < DEPTH; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h2000 + DW'(n);
      acc = s_tready;
      step();
      if (acc) n++;
    end
    s_tdata = 32'hDEAD_BEEF;
    step();
    step();
    checks++;
    if (s_tready !== 1'b0 || level !== 5'd16) begin
      failures++;
      $display("FAIL fill_full got rdy=%b l=%0d exp rdy=0 l=16",
               s_tready, level);
    end
    checks++;
    if (af !== 1'b1 || ae !== 1'b0) begin
      failures++;
      $display("FAIL fill_flags got af=%b ae=%b exp 1/0", af, ae);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      s_tdata = 32'h1000 + DW'(i);
      step();
      if (i >= 1) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h1000 + DW'(i - 1)
            || level !== 5'd2) begin
          failures++;
          $display("FAIL stream_%0d got v=%b d=%h l=%0d exp 1 %h 2",
                   i, m_tvalid, m_tdata, level,
                   32'h1000 + DW'(i - 1));
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      if (i < 5000) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        m_tready = ($urandom_range(0, 3) == 0);
      end else begin
        s_tvalid = ($urandom_range(0, 3) == 0);
        m_tready = ($urandom_range(0, 3) != 0);
      end
      s_tdata = $urandom;
      step();
    end
    drain();
  endtask

  task automatic test_drop();
    logic [DW-1:0] q [$];
    logic [DW-1:0] e;
    d_m_tready = 1'b0;
    d_s_tvalid = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      d_s_tdata = DW'(i);
      q.push_back(DW'(i));
      step();
    end
    checks++;
    if (d_level !== 5'd16 || d_af !== 1'b1 || d_s_tready !== 1'b1) begin
      failures++;
      $display("FAIL drop_full got l=%0d af=%b rdy=%b exp 16/1/1",
               d_level, d_af, d_s_tready);
    end
    for (int i = 0; i < 3; i++) begin
      d_s_tdata = 32'hD0 + DW'(i);
      step();
    end
    checks++;
    if (d_dcnt !== 16'd3 || d_level !== 5'd16 || d_m_tdata !== 32'h1) begin
      failures++;
      $display("FAIL drop_cnt got dc=%0d l=%0d d=%h exp 3/16/1",
               d_dcnt, d_level, d_m_tdata);
    end
    d_m_tready = 1'b1;
    d_s_tdata  = 32'hE0;
    void'(q.pop_front());
    q.push_back(32'hE0);
    step();
    d_s_tvalid = 1'b0;
    checks++;
    if (d_dcnt !== 16'd3 || d_level !== 5'd16) begin
      failures++;
      $display("FAIL drop_rw got dc=%0d l=%0d exp 3/16",
               d_dcnt, d_level);
    end
    for (int i = 0; i < 40 && d_level != 0; i++) begin
      if (d_m_tvalid) begin
        e = (q.size() != 0) ? q.pop_front() : 32'hFFFF_FFFF;
        checks++;
        if (d_m_tdata !== e) begin
          failures++;
          $display("FAIL drop_seq got=%h exp=%h", d_m_tdata, e);
        end
      end
      step();
    end
    checks++;
    if (q.size() != 0 || d_level !== '0) begin
      failures++;
      $display("FAIL drop_drain got left=%0d l=%0d exp 0/0",
               q.size(), d_level);
    end
    d_m_tready = 1'b0;
  endtask

  task automatic test_flush();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_tdata = 32'h3000 + DW'(i);
      step();
    end
    checks++;
    if (level !== 5'd7) begin
      failures++;
      $display("FAIL flush_pre got l=%0d exp 7", level);
    end
    flush    = 1'b1;
    m_tready = 1'b1;
    step();
    flush    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    checks++;
    if (level !== '0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clr got l=%0d v=%b exp 0/0",
               level, m_tvalid);
    end
    checks++;
    if (d_dcnt !== 16'd3 || d_level !== '0) begin
      failures++;
      $display("FAIL flush_keep got dc=%0d l=%0d exp 3/0",
               d_dcnt, d_level);
    end
  endtask

  task automatic test_rst_mid();
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tdata = 32'h4000 + DW'(i);
      step();
    end
    rst = 1'b1;
    step();
    rst      = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    checks++;
    if (level !== '0 || m_tvalid !== 1'b0 || m_tdata !== '0) begin
      failures++;
      $display("FAIL rst_mid got l=%0d v=%b d=%h exp 0/0/0",
               level, m_tvalid, m_tdata);
    end
    checks++;
    if (d_dcnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_dcnt got=%0d exp=0", d_dcnt);
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'hAB;
    step();
    s_tvalid = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_lat1 got v=%b exp 0", m_tvalid);
    end
    step();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hAB) begin
      failures++;
      $display("FAIL rst_lat2 got v=%b d=%h exp 1/ab",
               m_tvalid, m_tdata);
    end
    drain();
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b0;
    d_s_tdata  = '0;
    d_s_tvalid = 1'b0;
    d_m_tready = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_back_to_back();
    test_random();
    test_drop();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
